// File: rtl/interrupt_pc_sequencer_if.sv
// Bundle between the jump control block, the interrupt sources and the PC mux / fetch stage.
// The slave side is the interrupt sequencer; the master side drives requests and pipeline state.
interface interrupt_pc_sequencer_if #(
   parameter int ADDR_W  = 8,
   parameter int INS_W   = 20,
   parameter int FLAG_W  = 4,
   parameter int NUM_IRQ = 4
);
   logic [NUM_IRQ-1:0] irq_req;
   logic [NUM_IRQ-1:0] irq_mask;
   logic [INS_W-1:0]   ins;
   logic [ADDR_W-1:0]  current_address;
   logic [FLAG_W-1:0]  flag_ex;
   logic               stall;
   logic               jcb_pc_mux_sel;
   logic [ADDR_W-1:0]  jcb_jmp_loc;

   logic               pc_mux_sel;
   logic [ADDR_W-1:0]  jmp_loc;
   logic               flush;
   logic [FLAG_W-1:0]  flag_restore;
   logic               flag_restore_en;
   logic [NUM_IRQ-1:0] irq_ack;
   logic               in_isr;

   modport master (
      output irq_req, irq_mask, ins, current_address, flag_ex, stall,
             jcb_pc_mux_sel, jcb_jmp_loc,
      input  pc_mux_sel, jmp_loc, flush, flag_restore, flag_restore_en,
             irq_ack, in_isr
   );

   modport slave (
      input  irq_req, irq_mask, ins, current_address, flag_ex, stall,
             jcb_pc_mux_sel, jcb_jmp_loc,
      output pc_mux_sel, jmp_loc, flush, flag_restore, flag_restore_en,
             irq_ack, in_isr
   );
endinterface

// File: rtl/interrupt_pc_sequencer.sv
// Interrupt entry/return sequencer: arbitrates the PC redirect between the jump control block
// and a prioritised set of interrupt lines, saving and restoring return address and flags.
module interrupt_pc_sequencer #(
   parameter int                ADDR_W      = 8,
   parameter int                INS_W       = 20,
   parameter int                FLAG_W      = 4,
   parameter int                NUM_IRQ     = 4,
   parameter logic [ADDR_W-1:0] VECTOR_BASE = 8'hF0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   interrupt_pc_sequencer_if.slave  bus
);
   localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
   localparam logic [4:0] OP_RETI = 5'b10000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ENTER  = 2'd1,
      ST_ISR    = 2'd2,
      ST_RETURN = 2'd3
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   saved_addr_q;
   logic [FLAG_W-1:0]   saved_flag_q;
   logic [IDX_W-1:0]    irq_idx_q;

   logic [NUM_IRQ-1:0]  pend;
   logic                pend_any;
   logic [IDX_W-1:0]    pend_idx;
   logic                is_reti;
   logic [ADDR_W-1:0]   vector_addr;
   logic [NUM_IRQ-1:0]  ack_onehot;
   logic                unused_ins;

   logic                pc_sel;
   logic [ADDR_W-1:0]   jmp_tgt;
   logic                flush_c;
   logic [FLAG_W-1:0]   flag_rst;
   logic                flag_rst_en;
   logic [NUM_IRQ-1:0]  ack;

   assign pend       = bus.irq_req & bus.irq_mask;
   assign pend_any   = |pend;
   assign is_reti    = (bus.ins[INS_W-1:INS_W-5] == OP_RETI);
   assign unused_ins = ^bus.ins[INS_W-6:0];

   // Lowest-numbered pending line has priority: scan downwards so the last hit wins.
   always_comb begin
      pend_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pend[i]) begin
            pend_idx = IDX_W'(i);
         end
      end
   end

   assign vector_addr = VECTOR_BASE + (ADDR_W'(irq_idx_q) << 1);

   generate
      for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_ack
         assign ack_onehot[gi] = (irq_idx_q == IDX_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         saved_addr_q <= '0;
         saved_flag_q <= '0;
         irq_idx_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pend_any && !bus.stall) begin
                  irq_idx_q    <= pend_idx;
                  saved_flag_q <= bus.flag_ex;
                  // A jump resolving in this cycle must be honoured on return.
                  saved_addr_q <= bus.jcb_pc_mux_sel ? bus.jcb_jmp_loc : bus.current_address;
                  state_q      <= ST_ENTER;
               end
            end
            ST_ENTER: begin
               if (!bus.stall) begin
                  state_q <= ST_ISR;
               end
            end
            ST_ISR: begin
               if (is_reti && !bus.stall) begin
                  state_q <= ST_RETURN;
               end
            end
            ST_RETURN: begin
               if (!bus.stall) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the registered state; the jump path is forced off during reset.
   always_comb begin
      pc_sel      = 1'b0;
      jmp_tgt     = '0;
      flush_c     = 1'b0;
      flag_rst    = '0;
      flag_rst_en = 1'b0;
      ack         = '0;
      if (rst_n) begin
         case (state_q)
            ST_IDLE, ST_ISR: begin
               pc_sel  = bus.jcb_pc_mux_sel;
               jmp_tgt = bus.jcb_jmp_loc;
            end
            ST_ENTER: begin
               pc_sel  = 1'b1;
               jmp_tgt = vector_addr;
               flush_c = 1'b1;
               if (!bus.stall) begin
                  ack = ack_onehot;
               end
            end
            ST_RETURN: begin
               pc_sel      = 1'b1;
               jmp_tgt     = saved_addr_q;
               flush_c     = 1'b1;
               flag_rst    = saved_flag_q;
               flag_rst_en = 1'b1;
            end
            default: begin
               pc_sel = 1'b0;
            end
         endcase
      end
   end

   assign bus.pc_mux_sel      = pc_sel;
   assign bus.jmp_loc         = jmp_tgt;
   assign bus.flush           = flush_c;
   assign bus.flag_restore    = flag_rst;
   assign bus.flag_restore_en = flag_rst_en;
   assign bus.irq_ack         = ack;
   assign bus.in_isr          = rst_n && (state_q != ST_IDLE);
endmodule

// File: tb/tb_interrupt_pc_sequencer.sv
// Directed bench for interrupt_pc_sequencer: entry, priority/masking, return, stalls and reset.
module tb_interrupt_pc_sequencer;
   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   localparam logic [19:0] RETI = 20'h80000;
   localparam logic [19:0] JMPI = 20'h08000;

   interrupt_pc_sequencer_if bus ();

   interrupt_pc_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic e_pc, input logic [7:0] e_jmp,
                            input logic e_fl, input logic [3:0] e_fr, input logic e_fre,
                            input logic [3:0] e_ack, input logic e_isr);
      #1;
      chk({tag, ".pc_mux_sel"},      32'(bus.pc_mux_sel),      32'(e_pc));
      chk({tag, ".jmp_loc"},         32'(bus.jmp_loc),         32'(e_jmp));
      chk({tag, ".flush"},           32'(bus.flush),           32'(e_fl));
      chk({tag, ".flag_restore"},    32'(bus.flag_restore),    32'(e_fr));
      chk({tag, ".flag_restore_en"}, 32'(bus.flag_restore_en), 32'(e_fre));
      chk({tag, ".irq_ack"},         32'(bus.irq_ack),         32'(e_ack));
      chk({tag, ".in_isr"},          32'(bus.in_isr),          32'(e_isr));
      $display("t=%0t %s pc_sel=%b jmp=%h flush=%b fr=%h fre=%b ack=%b isr=%b", $time, tag,
               bus.pc_mux_sel, bus.jmp_loc, bus.flush, bus.flag_restore,
               bus.flag_restore_en, bus.irq_ack, bus.in_isr);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n               = 1'b0;
      bus.irq_req         = 4'b0000;
      bus.irq_mask        = 4'hF;
      bus.ins             = '0;
      bus.current_address = 8'h00;
      bus.flag_ex         = 4'b0000;
      bus.stall           = 1'b0;
      bus.jcb_pc_mux_sel  = 1'b1;
      bus.jcb_jmp_loc     = 8'h55;
      #2;
      check_out("reset", 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0);
      #10 rst_n = 1'b1;
      tick();
      check_out("idle_pass", 1'b1, 8'h55, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0);

      // 1: basic entry on line 2 and return
      bus.jcb_pc_mux_sel  = 1'b0;
      bus.jcb_jmp_loc     = 8'h00;
      bus.current_address = 8'h12;
      bus.flag_ex         = 4'b0011;
      bus.irq_req         = 4'b0100;
      check_out("t1_pre", 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0);
      tick();
      bus.irq_req = 4'b0000;
      bus.flag_ex = 4'b0000;
      check_out("t1_enter", 1'b1, 8'hF4, 1'b1, 4'h0, 1'b0, 4'b0100, 1'b1);
      tick();
      check_out("t1_isr", 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b1);
      bus.ins = RETI;
      tick();
      bus.ins = '0;
      check_out("t1_return", 1'b1, 8'h12, 1'b1, 4'b0011, 1'b1, 4'b0000, 1'b1);
      tick();
      check_out("t1_idle", 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0);

      // 2: masking and priority among enabled lines
      bus.irq_req         = 4'b1010;
      bus.irq_mask        = 4'b0000;
      bus.current_address = 8'h20;
      bus.flag_ex         = 4'b0101;
      bus.jcb_pc_mux_sel  = 1'b1;
      bus.jcb_jmp_loc     = 8'h33;
      tick();
      check_out("t2_masked", 1'b1, 8'h33, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0);
      bus.jcb_pc_mux_sel = 1'b0;
      bus.jcb_jmp_loc    = 8'h00;
      bus.irq_mask       = 4'b1000;
      tick();
      bus.irq_req = 4'b0000;
      check_out("t2_enter", 1'b1, 8'hF6, 1'b1, 4'h0, 1'b0, 4'b1000, 1'b1);
      tick();
      bus.ins = RETI;
      tick();
      bus.ins = '0;
      check_out("t2_return", 1'b1, 8'h20, 1'b1, 4'b0101, 1'b1, 4'b0000, 1'b1);
      tick();
      bus.irq_mask = 4'hF;

      // 3: interrupt taken while a jump resolves; return goes to the jump target
      bus.irq_req         = 4'b0001;
      bus.current_address = 8'h30;
      bus.flag_ex         = 4'b0010;
      bus.jcb_pc_mux_sel  = 1'b1;
      bus.jcb_jmp_loc     = 8'h40;
      tick();
      bus.ins = JMPI;
      check_out("t3_enter", 1'b1, 8'hF0, 1'b1, 4'h0, 1'b0, 4'b0001, 1'b1);
      bus.irq_req        = 4'b0000;
      bus.jcb_pc_mux_sel = 1'b0;
      bus.jcb_jmp_loc    = 8'h00;
      tick();
      bus.ins = RETI;
      tick();
      bus.ins            = JMPI;
      bus.jcb_pc_mux_sel = 1'b1;
      bus.jcb_jmp_loc    = 8'h99;
      check_out("t3_return", 1'b1, 8'h40, 1'b1, 4'b0010, 1'b1, 4'b0000, 1'b1);
      tick();
      bus.ins            = '0;
      bus.jcb_pc_mux_sel = 1'b0;
      bus.jcb_jmp_loc    = 8'h00;

      // 4: held requests during ISR, re-entry only after an IDLE cycle
      bus.irq_req         = 4'b0001;
      bus.current_address = 8'h50;
      bus.flag_ex         = 4'b0000;
      tick();
      check_out("t4_enter", 1'b1, 8'hF0, 1'b1, 4'h0, 1'b0, 4'b0001, 1'b1);
      bus.irq_req = 4'b0011;
      tick();
      check_out("t4_isr_a", 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b1);
      tick();
      check_out("t4_isr_b", 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b1);
      bus.ins = RETI;
      tick();
      bus.ins = '0;
      check_out("t4_return", 1'b1, 8'h50, 1'b1, 4'h0, 1'b1, 4'b0000, 1'b1);
      tick();
      check_out("t4_idle_gap", 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0);
      tick();
      check_out("t4_reenter", 1'b1, 8'hF0, 1'b1, 4'h0, 1'b0, 4'b0001, 1'b1);
      bus.irq_req = 4'b0000;
      tick();
      bus.ins = RETI;
      tick();
      bus.ins = '0;
      tick();

      // 5: stalled ENTER with request/mask changes, stalled RETURN, RETI in IDLE
      bus.irq_req         = 4'b0010;
      bus.current_address = 8'h60;
      bus.flag_ex         = 4'b1001;
      tick();
      bus.stall    = 1'b1;
      bus.irq_req  = 4'b0001;
      bus.irq_mask = 4'b0000;
      check_out("t5_stall0", 1'b1, 8'hF2, 1'b1, 4'h0, 1'b0, 4'b0000, 1'b1);
      tick();
      check_out("t5_stall1", 1'b1, 8'hF2, 1'b1, 4'h0, 1'b0, 4'b0000, 1'b1);
      tick();
      check_out("t5_stall2", 1'b1, 8'hF2, 1'b1, 4'h0, 1'b0, 4'b0000, 1'b1);
      tick();
      bus.stall = 1'b0;
      check_out("t5_exit", 1'b1, 8'hF2, 1'b1, 4'h0, 1'b0, 4'b0010, 1'b1);
      tick();
      check_out("t5_isr", 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b1);
      bus.ins = RETI;
      tick();
      bus.ins   = '0;
      bus.stall = 1'b1;
      check_out("t5_ret_stall", 1'b1, 8'h60, 1'b1, 4'b1001, 1'b1, 4'b0000, 1'b1);
      tick();
      check_out("t5_ret_held", 1'b1, 8'h60, 1'b1, 4'b1001, 1'b1, 4'b0000, 1'b1);
      bus.stall = 1'b0;
      tick();
      check_out("t5_idle", 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0);
      bus.ins = RETI;
      tick();
      check_out("t5_reti_idle", 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0);
      bus.ins      = '0;
      bus.irq_req  = 4'b0000;
      bus.irq_mask = 4'hF;

      // 6: asynchronous reset in the middle of an ISR
      bus.irq_req = 4'b1000;
      tick();
      bus.irq_req = 4'b0000;
      tick();
      bus.jcb_pc_mux_sel = 1'b1;
      bus.jcb_jmp_loc    = 8'h77;
      check_out("t6_isr_pass", 1'b1, 8'h77, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b1);
      rst_n = 1'b0;
      check_out("t6_async_rst", 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0);
      #3 rst_n = 1'b1;
      tick();
      bus.ins = RETI;
      tick();
      check_out("t6_after_rst", 1'b1, 8'h77, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
